hvtx_period_sched: RTL and testbench
====================================

// Module: hvtx_period_sched
// PURPOSE
//  Per-pixel HDMI period scheduler for the TX path. Consumes cursor x/y and classifies every pixel as:
//  control, video preamble/guard/active, or data-island preamble/guard/packet. Drives CTL3..0 for the
//  ctl channels and hands out data-island packet slots to a packet source via a req/ack handshake.
//  Outputs share the 1-cycle latency of hvtx_sync so they align with o_hs/o_vs/o_de.
// PARAMETERS
//  WIDTH         12    coordinate width
//  FRAME_WIDTH   1650  total pixels per line
//  FRAME_HEIGHT  750   total lines per frame
//  ACTIVE_WIDTH  1280  active pixels per line
//  ACTIVE_HEIGHT 720   active lines per frame
//  ISLAND_GAP    10    control pixels between end of active video and island preamble
//  MAX_PKTS      18    max packets per island (1..31)
// PORTS
//  i_clk       in   1      pixel clock
//  i_rst       in   1      asynchronous reset, active-high
//  i_x         in   WIDTH  cursor x
//  i_y         in   WIDTH  cursor y
//  i_pkt_req   in   1      level: source has >=1 packet pending
//  o_pkt_ack   out  1      1-cycle pulse on pixel 0 of each granted packet
//  o_pkt_idx   out  5      pixel index within current packet, 0..31
//  o_period    out  3      0 CTRL,1 VID_PRE,2 VID_GB,3 VID_ACT,4 DI_PRE,5 DI_GB,6 DI_PKT
//  o_ctl       out  4      CTL3..CTL0: 4'b0001 in VID_PRE, 4'b0101 in DI_PRE, else 4'b0000
// BEHAVIOUR
//  - Reset (async): o_period=CTRL, o_ctl=0, o_pkt_ack=0, o_pkt_idx=0, FSM=IDLE, counters=0.
//  - All outputs registered; values out at cycle t+1 describe the pixel whose i_x/i_y were sampled at t.
//  - Constants: PRE_V=FRAME_WIDTH-10, GB_V=FRAME_WIDTH-2, ISL=ACTIVE_WIDTH+ISLAND_GAP.
//  - ynext = (i_y==FRAME_HEIGHT-1) ? 0 : i_y+1. Video-preamble lines are those with ynext<ACTIVE_HEIGHT.
//  - Video (combinational from x/y, overrides the FSM):
//    VID_ACT  when i_x<ACTIVE_WIDTH && i_y<ACTIVE_HEIGHT.
//    VID_PRE  when i_x in [PRE_V,GB_V-1] on a video-preamble line.
//    VID_GB   when i_x in [GB_V,FRAME_WIDTH-1] on a video-preamble line.
//  - Island FSM states: IDLE, PRE (8 px), LGB (2 px), PKT (32 px each), TGB (2 px).
//  - Island open: IDLE->PRE at i_x==ISL when i_pkt_req=1 and ISL+8+2+32+2+12<=PRE_V.
//    Otherwise remain IDLE for that line. Check is evaluated on every line, including vertical blanking.
//  - Phase sequence:
//    PRE: 8 px, then LGB.
//    LGB: 2 px, then PKT with packet count=0.
//    PKT: o_pkt_idx counts 0..31. o_pkt_ack=1 on idx 0.
//  - Packet boundary (idx 31): next pixel is xs=i_x+1. Continue into another PKT iff all of:
//    i_pkt_req=1 (sampled at idx 31), count+1<MAX_PKTS, xs+32+2+12<=PRE_V. Otherwise TGB (2 px), then IDLE.
//  - The ack pulse on packet pixel 0 means the source is consumed one packet. The source must update
//    i_pkt_req by the following idx-31 sample.
//  - i_pkt_req dropping mid-packet does not abort the packet. The packet always completes all 32 px.
//  - Robustness: if i_x<ACTIVE_WIDTH (cursor reset or jump), the FSM is forced to IDLE and counters clear.
//  - Mid-operation i_rst drops the island immediately, with no trailing guard.
//  - Any pixel that is neither video nor an island phase is CTRL.
//  - Island and video-preamble windows never overlap, by construction of the room rule (>=12 CTRL px before PRE_V).
//  - Counters: pixel counter 5-bit wraps 31->0 only on a continued packet. Packet counter is 5-bit, with no wrap beyond MAX_PKTS-1.
// TESTING
//  1. Default params, i_pkt_req=0: x 1280..1639 -> CTRL. x 1640..1647 -> VID_PRE, ctl 0001.
//     x 1648..1649 -> VID_GB. y=0 x=0 -> VID_ACT.
//  2. i_pkt_req=1 held: DI_PRE at x 1290..1297 (ctl 0101), DI_GB at 1298..1299.
//     10 packets start at 1300 + 32k (k=0..9) with ack each. Trailing DI_GB at 1620..1621. CTRL 1622..1639.
//  3. MAX_PKTS=2, req held -> exactly 2 acks (x 1300, 1332). DI_GB at 1364..1365.
//  4. Req drops after the first ack -> 1 packet. TGB at 1332..1333. Req=0 at x=1290 sample -> no island that line.
//  5. y=719 vs y=749 -> line 719 has no VID_PRE/VID_GB. Line 749 (wrap to y=0) has them.
//     Islands still occur on line 725 (vblank).
//  6. Assert i_rst at packet idx 10 -> outputs reset asynchronously. After release, CTRL until the next line's x=1290.
//     A cursor jump to x=0 mid-island gives VID_ACT/CTRL, FSM IDLE.

Source files
------------

// File: rtl/hvtx_period_sched.sv
// Per-pixel HDMI TX period scheduler: classifies each pixel (control / video / data island),
// drives CTL3..0 and grants data-island packet slots to a packet source via req/ack.
module hvtx_period_sched #(
    parameter int unsigned WIDTH         = 12,
    parameter int unsigned FRAME_WIDTH   = 1650,
    parameter int unsigned FRAME_HEIGHT  = 750,
    parameter int unsigned ACTIVE_WIDTH  = 1280,
    parameter int unsigned ACTIVE_HEIGHT = 720,
    parameter int unsigned ISLAND_GAP    = 10,
    parameter int unsigned MAX_PKTS      = 18
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_pkt_req,
    output logic             o_pkt_ack,
    output logic [4:0]       o_pkt_idx,
    output logic [2:0]       o_period,
    output logic [3:0]       o_ctl
);

    localparam int unsigned PRE_V = FRAME_WIDTH - 10;
    localparam int unsigned GB_V  = FRAME_WIDTH - 2;
    localparam int unsigned ISL   = ACTIVE_WIDTH + ISLAND_GAP;
    localparam bit          ROOM  = (ISL + 8 + 2 + 32 + 2 + 12 <= PRE_V);

    typedef enum logic [2:0] {
        CTRL    = 3'd0,
        VID_PRE = 3'd1,
        VID_GB  = 3'd2,
        VID_ACT = 3'd3,
        DI_PRE  = 3'd4,
        DI_GB   = 3'd5,
        DI_PKT  = 3'd6
    } period_t;

    typedef enum logic [2:0] {IDLE, PRE, LGB, PKT, TGB} phase_t;

    phase_t      state, state_nx, cur;
    logic [4:0]  pcnt, pcnt_nx, kcnt, kcnt_nx;
    logic [31:0] x32, y32, ynext, xs;
    logic        pre_line, cont;

    period_t     period_d, period_q;
    logic [3:0]  ctl_d;
    logic        ack_d;
    logic [4:0]  idx_d;

    assign x32      = 32'(i_x);
    assign y32      = 32'(i_y);
    assign xs       = x32 + 32'd1;
    assign ynext    = (y32 == FRAME_HEIGHT - 1) ? '0 : y32 + 32'd1;
    assign pre_line = (ynext < ACTIVE_HEIGHT);
    assign cont     = i_pkt_req && (32'(kcnt) + 32'd1 < MAX_PKTS)
                      && (xs + 32'd46 <= PRE_V);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            pcnt  <= '0;
            kcnt  <= '0;
        end else begin
            state <= state_nx;
            pcnt  <= pcnt_nx;
            kcnt  <= kcnt_nx;
        end
    end

    // cur is the phase of the pixel now at i_x; the island opens on the very pixel at ISL
    always_comb begin
        cur = state;
        if (x32 < ACTIVE_WIDTH)
            cur = IDLE;
        else if (state == IDLE && x32 == ISL && i_pkt_req && ROOM)
            cur = PRE;
        state_nx = cur;
        pcnt_nx  = pcnt + 5'd1;
        kcnt_nx  = kcnt;
        case (cur)
            IDLE: begin
                pcnt_nx = '0;
                kcnt_nx = '0;
            end
            PRE: if (pcnt == 5'd7) begin
                state_nx = LGB;
                pcnt_nx  = '0;
            end
            LGB: if (pcnt == 5'd1) begin
                state_nx = PKT;
                pcnt_nx  = '0;
                kcnt_nx  = '0;
            end
            PKT: if (pcnt == 5'd31) begin
                if (cont) kcnt_nx = kcnt + 5'd1;
                else begin
                    state_nx = TGB;
                    pcnt_nx  = '0;
                end
            end
            TGB: if (pcnt == 5'd1) begin
                state_nx = IDLE;
                pcnt_nx  = '0;
            end
            default: begin
                state_nx = IDLE;
                pcnt_nx  = '0;
                kcnt_nx  = '0;
            end
        endcase
    end

    always_comb begin
        period_d = CTRL;
        ack_d    = 1'b0;
        idx_d    = '0;
        if (x32 < ACTIVE_WIDTH && y32 < ACTIVE_HEIGHT)
            period_d = VID_ACT;
        else if (pre_line && x32 >= PRE_V && x32 < GB_V)
            period_d = VID_PRE;
        else if (pre_line && x32 >= GB_V && x32 < FRAME_WIDTH)
            period_d = VID_GB;
        else begin
            case (cur)
                PRE:      period_d = DI_PRE;
                LGB, TGB: period_d = DI_GB;
                PKT: begin
                    period_d = DI_PKT;
                    ack_d    = (pcnt == 5'd0);
                    idx_d    = pcnt;
                end
                default:  period_d = CTRL;
            endcase
        end
        case (period_d)
            VID_PRE: ctl_d = 4'b0001;
            DI_PRE:  ctl_d = 4'b0101;
            default: ctl_d = 4'b0000;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            period_q  <= CTRL;
            o_ctl     <= '0;
            o_pkt_ack <= 1'b0;
            o_pkt_idx <= '0;
        end else begin
            period_q  <= period_d;
            o_ctl     <= ctl_d;
            o_pkt_ack <= ack_d;
            o_pkt_idx <= idx_d;
        end
    end

    assign o_period = period_q;

endmodule

// File: tb/tb_hvtx_period_sched.sv
// Randomized line-scan bench for hvtx_period_sched: two instances (MAX_PKTS 18 and 2)
// compared pixel-by-pixel against a position-based island model.
module tb_hvtx_period_sched;

    localparam int FW = 1650, FH = 750, AW = 1280, AH = 720, GAP = 10;
    localparam int PRE_V = FW - 10, GB_V = FW - 2, ISL = AW + GAP;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] x, y;
    logic        req;
    logic        ack_a, ack_b;
    logic [4:0]  idx_a, idx_b;
    logic [2:0]  per_a, per_b;
    logic [3:0]  ctl_a, ctl_b;

    int vectors = 0;
    int miscompares = 0;
    int cx, cy;

    // model state per instance, expressed as x positions of island landmarks
    int m_on[2], m_isl[2], m_pkt[2], m_npk[2], m_tgb[2];
    int m_max[2] = '{18, 2};

    always #5 clk = ~clk;

    hvtx_period_sched u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_pkt_req(req),
        .o_pkt_ack(ack_a), .o_pkt_idx(idx_a), .o_period(per_a), .o_ctl(ctl_a)
    );

    hvtx_period_sched #(.MAX_PKTS(2)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y), .i_pkt_req(req),
        .o_pkt_ack(ack_b), .o_pkt_idx(idx_b), .o_period(per_b), .o_ctl(ctl_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at x=%0d y=%0d: got %0d, expected %0d", tag, cx, cy, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) m_on[k] = 0;
    endtask

    task automatic model(input int k, input int px, input int py, input int rq,
                         output int per, output int ctl, output int ack, output int idx);
        int yn, off, pi;
        per = 0; ack = 0; idx = 0;
        if (px < AW) m_on[k] = 0;
        if (!m_on[k] && px == ISL && rq != 0 && (ISL + 56 <= PRE_V)) begin
            m_on[k] = 1; m_isl[k] = px; m_pkt[k] = px + 10; m_npk[k] = 1; m_tgb[k] = -1;
        end
        if (m_on[k]) begin
            off = px - m_isl[k];
            if (off < 8) per = 4;
            else if (off < 10) per = 5;
            else if (m_tgb[k] < 0) begin
                per = 6;
                pi  = px - m_pkt[k];
                idx = pi;
                ack = (pi == 0);
                if (pi == 31) begin
                    if (rq != 0 && m_npk[k] < m_max[k] && px + 1 + 46 <= PRE_V) begin
                        m_pkt[k] = px + 1; m_npk[k]++;
                    end else m_tgb[k] = px + 1;
                end
            end else begin
                per = 5;
                if (px - m_tgb[k] == 1) m_on[k] = 0;
            end
        end
        yn = (py == FH - 1) ? 0 : py + 1;
        if (px < AW && py < AH) per = 3;
        else if (yn < AH && px >= PRE_V && px < GB_V) per = 1;
        else if (yn < AH && px >= GB_V && px < FW) per = 2;
        ctl = (per == 1) ? 1 : (per == 4) ? 5 : 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_period_a", per_a, 0); check("rst_ctl_a", ctl_a, 0);
        check("rst_ack_a", ack_a, 0);    check("rst_idx_a", idx_a, 0);
        check("rst_period_b", per_b, 0); check("rst_ctl_b", ctl_b, 0);
        check("rst_ack_b", ack_b, 0);    check("rst_idx_b", idx_b, 0);
    endtask

    // mode: 0 req low, 1 req high, 2 random req, 3 req drops after first ack
    task automatic run_line(input int ly, input int mode, input int jump_at, input int rst_at);
        int px, jumped, acked;
        int pa, ca, aa, ia, pb, cb, ab, ib;
        px = 0; jumped = 0; acked = 0;
        while (px < FW) begin
            x = 12'(px); y = 12'(ly);
            case (mode)
                0: req = 1'b0;
                1: req = 1'b1;
                2: req = ($urandom_range(0, 3) != 0);
                default: req = !acked;
            endcase
            model(0, px, ly, int'(req), pa, ca, aa, ia);
            model(1, px, ly, int'(req), pb, cb, ab, ib);
            if (aa != 0) acked = 1;
            @(posedge clk);
            #1;
            cx = px; cy = ly;
            check("period_a", per_a, pa); check("ctl_a", ctl_a, ca); check("ack_a", ack_a, aa);
            if (pa == 6) check("idx_a", idx_a, ia);
            check("period_b", per_b, pb); check("ctl_b", ctl_b, cb); check("ack_b", ack_b, ab);
            if (pb == 6) check("idx_b", idx_b, ib);
            if (px == rst_at) begin
                #1 rst = 1'b1;
                #1 check_reset_outputs();
                model_clear();
                #1 rst = 1'b0;
            end
            if (!jumped && jump_at >= 0 && px == jump_at) begin
                jumped = 1;
                px = 0;
            end else px++;
        end
    endtask

    initial begin
        rst = 1'b1; x = '0; y = '0; req = 1'b0;
        cx = 0; cy = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        rst = 1'b0;

        run_line(100, 0, -1, -1);
        run_line(100, 1, -1, -1);
        run_line(101, 3, -1, -1);
        run_line(719, 1, -1, -1);
        run_line(749, 0, -1, -1);
        run_line(725, 1, -1, -1);
        run_line(0,   1, -1, 1310);
        run_line(1,   1, -1, -1);
        run_line(5,   1, 1400, -1);
        run_line(730, 2, -1, -1);
        for (int i = 0; i < 6; i++)
            run_line($urandom_range(0, FH - 1), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1290, 1640) : -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
